// File: rtl/config_data_assembler.sv
// Purpose: gathers strobed config words into one wide word for the TM shift-register writer.
// Latency: data_out/done update one clock after the edge that captures the last word.
// Backpressure: none; accepts one word per clock, including the word that arrives during LOAD.
//
// Ports: clk_in/rst_n clock and async active-low reset; data_in+pulse word strobe;
//        clear aborts the partial frame; data_out/done completed frame; busy, word_cnt
//        frame progress; timeout_err flags a partial frame dropped after an idle gap.
module config_data_assembler #(
    parameter int DATA_WIDTH     = 170,
    parameter int WORD_WIDTH     = 16,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int NUM_WORDS     = (DATA_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH,
    localparam int TMP_WIDTH     = NUM_WORDS * WORD_WIDTH,
    localparam int CNT_W         = $clog2(NUM_WORDS + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  pulse,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  done,
    output logic                  busy,
    output logic [CNT_W-1:0]      word_cnt,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_LOAD} state_t;

    localparam bit     TO_EN       = (TIMEOUT_CYCLES > 0);
    localparam int     IDLE_W      = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(NUM_WORDS - 1);
    // A single-word frame goes straight from its strobe to LOAD.
    localparam state_t FIRST_STATE = (NUM_WORDS == 1) ? S_LOAD : S_COLLECT;
    localparam bit     FIRST_BUSY  = (NUM_WORDS != 1);

    state_t                 state;
    logic [TMP_WIDTH-1:0]   frame_buf;
    logic [IDLE_W-1:0]      idle_cnt;
    logic [TMP_WIDTH-1:0]   first_buf;
    logic [DATA_WIDTH-1:0]  assembled;
    logic                   unused_pad;

    // Overwrite slot 'slot' of the buffer with 'w'; other slots are untouched.
    function automatic logic [TMP_WIDTH-1:0] place_word(
        input logic [TMP_WIDTH-1:0]  b,
        input logic [CNT_W-1:0]      slot,
        input logic [WORD_WIDTH-1:0] w
    );
        logic [TMP_WIDTH-1:0] r;
        r = b;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (slot == CNT_W'(k)) begin
                if (MSB_FIRST != 0) r[TMP_WIDTH-1-k*WORD_WIDTH -: WORD_WIDTH] = w;
                else                r[k*WORD_WIDTH +: WORD_WIDTH] = w;
            end
        end
        return r;
    endfunction

    // A new frame always starts from an empty buffer, so word 0 lands on zeros.
    assign first_buf = place_word('0, '0, data_in);

    // The padding slice (top for LSB-first, bottom for MSB-first) never reaches data_out.
    generate
        if (MSB_FIRST != 0) begin : g_msb
            assign assembled = frame_buf[TMP_WIDTH-1 -: DATA_WIDTH];
            if (TMP_WIDTH > DATA_WIDTH) begin : g_pad
                assign unused_pad = ^frame_buf[TMP_WIDTH-DATA_WIDTH-1:0];
            end else begin : g_nopad
                assign unused_pad = 1'b0;
            end
        end else begin : g_lsb
            assign assembled = frame_buf[DATA_WIDTH-1:0];
            if (TMP_WIDTH > DATA_WIDTH) begin : g_pad
                assign unused_pad = ^frame_buf[TMP_WIDTH-1:DATA_WIDTH];
            end else begin : g_nopad
                assign unused_pad = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            frame_buf   <= '0;
            idle_cnt    <= '0;
            data_out    <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
            word_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            timeout_err <= 1'b0;
            if (clear) begin
                // Abort wins over everything, including a strobe this cycle.
                state     <= S_IDLE;
                frame_buf <= '0;
                idle_cnt  <= '0;
                word_cnt  <= '0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (pulse) begin
                            frame_buf <= first_buf;
                            word_cnt  <= CNT_ONE;
                            idle_cnt  <= '0;
                            state     <= FIRST_STATE;
                            busy      <= FIRST_BUSY;
                        end
                    end
                    S_COLLECT: begin
                        // A strobe in the expiry cycle is accepted; no error.
                        if (pulse) begin
                            frame_buf <= place_word(frame_buf, word_cnt, data_in);
                            word_cnt  <= word_cnt + CNT_ONE;
                            idle_cnt  <= '0;
                            if (word_cnt == LAST_IDX) begin
                                state <= S_LOAD;
                                busy  <= 1'b0;
                            end
                        end else if (TO_EN && idle_cnt == IDLE_LIMIT) begin
                            timeout_err <= 1'b1;
                            frame_buf   <= '0;
                            word_cnt    <= '0;
                            idle_cnt    <= '0;
                            state       <= S_IDLE;
                            busy        <= 1'b0;
                        end else if (TO_EN) begin
                            idle_cnt <= idle_cnt + IDLE_ONE;
                        end
                    end
                    S_LOAD: begin
                        data_out <= assembled;
                        done     <= 1'b1;
                        idle_cnt <= '0;
                        if (pulse) begin
                            frame_buf <= first_buf;
                            word_cnt  <= CNT_ONE;
                            state     <= FIRST_STATE;
                            busy      <= FIRST_BUSY;
                        end else begin
                            frame_buf <= '0;
                            word_cnt  <= '0;
                            state     <= S_IDLE;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        frame_buf <= '0;
                        idle_cnt  <= '0;
                        word_cnt  <= '0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_data_assembler.sv
// Purpose: directed self-checking bench for config_data_assembler in three parameterisations.
// Latency: checks are sampled 1 time unit after each rising clk_in edge.
// Backpressure: not applicable; stimulus is strobed one word per clock.
module tb_config_data_assembler;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // dut0: defaults (170/16, LSB-first, no timeout)
    logic [15:0]  d0 = '0;
    logic         p0 = 1'b0, c0 = 1'b0;
    logic [169:0] q0;
    logic         done0, busy0, terr0;
    logic [3:0]   cnt0;

    // dut1: MSB-first, 40/16
    logic [15:0]  d1 = '0;
    logic         p1 = 1'b0, c1 = 1'b0;
    logic [39:0]  q1;
    logic         done1, busy1, terr1;
    logic [1:0]   cnt1;

    // dut2: defaults with a 4-cycle timeout
    logic [15:0]  d2 = '0;
    logic         p2 = 1'b0, c2 = 1'b0;
    logic [169:0] q2;
    logic         done2, busy2, terr2;
    logic [3:0]   cnt2;

    config_data_assembler dut0 (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(d0), .pulse(p0), .clear(c0),
        .data_out(q0), .done(done0), .busy(busy0), .word_cnt(cnt0), .timeout_err(terr0)
    );

    config_data_assembler #(.DATA_WIDTH(40), .WORD_WIDTH(16), .MSB_FIRST(1)) dut1 (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(d1), .pulse(p1), .clear(c1),
        .data_out(q1), .done(done1), .busy(busy1), .word_cnt(cnt1), .timeout_err(terr1)
    );

    config_data_assembler #(.TIMEOUT_CYCLES(4)) dut2 (
        .clk_in(clk_in), .rst_n(rst_n), .data_in(d2), .pulse(p2), .clear(c2),
        .data_out(q2), .done(done2), .busy(busy2), .word_cnt(cnt2), .timeout_err(terr2)
    );

    typedef struct {
        logic        pulse;
        logic        clear;
        logic [15:0] dat;
        logic        exp_done;
        logic        exp_busy;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic p, input logic c, input logic [15:0] d,
                                    input logic e_done, input logic e_busy, input logic [3:0] e_cnt);
        vec_t v;
        v.pulse = p; v.clear = c; v.dat = d;
        v.exp_done = e_done; v.exp_busy = e_busy; v.exp_cnt = e_cnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [169:0] act, input logic [169:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    logic [169:0] exp_a, exp_b, exp_t;
    logic [15:0]  msb_words [3];
    int           ndone, first_done, second_done;

    initial begin
        // ---------------- reset state ----------------
        repeat (2) @(posedge clk_in);
        #1;
        chk("rst_data_out", q0, 170'd0);
        chk("rst_done", {169'd0, done0}, 170'd0);
        chk("rst_busy", {169'd0, busy0}, 170'd0);
        chk("rst_word_cnt", {166'd0, cnt0}, 170'd0);
        chk("rst_timeout_err", {169'd0, terr2}, 170'd0);
        chk("rst_dut1_data_out", {130'd0, q1}, 170'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- table: clear mid-frame, then a full default frame ----------------
        add_vec(1, 0, 16'h0101, 0, 1, 4'd1);
        add_vec(1, 0, 16'h0102, 0, 1, 4'd2);
        add_vec(1, 0, 16'h0103, 0, 1, 4'd3);
        add_vec(1, 0, 16'h0104, 0, 1, 4'd4);
        add_vec(1, 0, 16'h0105, 0, 1, 4'd5);
        add_vec(1, 1, 16'hDEAD, 0, 0, 4'd0);   // clear beats the strobe
        add_vec(1, 0, 16'h0001, 0, 1, 4'd1);
        add_vec(1, 0, 16'h0002, 0, 1, 4'd2);
        add_vec(1, 0, 16'h0003, 0, 1, 4'd3);
        add_vec(1, 0, 16'h0004, 0, 1, 4'd4);
        add_vec(1, 0, 16'h0005, 0, 1, 4'd5);
        add_vec(1, 0, 16'h0006, 0, 1, 4'd6);
        add_vec(1, 0, 16'h0007, 0, 1, 4'd7);
        add_vec(1, 0, 16'h0008, 0, 1, 4'd8);
        add_vec(1, 0, 16'h0009, 0, 1, 4'd9);
        add_vec(1, 0, 16'h000A, 0, 1, 4'd10);
        add_vec(1, 0, 16'h000B, 0, 0, 4'd11);  // last word: LOAD, busy drops
        add_vec(0, 0, 16'h0000, 1, 0, 4'd0);   // done one clock later
        add_vec(0, 0, 16'h0000, 0, 0, 4'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            p0 = vecs[i].pulse; c0 = vecs[i].clear; d0 = vecs[i].dat;
            tick();
            chk($sformatf("vec%0d_done", i), {169'd0, done0}, {169'd0, vecs[i].exp_done});
            chk($sformatf("vec%0d_busy", i), {169'd0, busy0}, {169'd0, vecs[i].exp_busy});
            chk($sformatf("vec%0d_word_cnt", i), {166'd0, cnt0}, {166'd0, vecs[i].exp_cnt});
        end
        p0 = 1'b0; c0 = 1'b0; d0 = '0;

        exp_a = '0;
        for (int k = 0; k < 11; k++) exp_a = exp_a | (170'(k + 1) << (16 * k));
        chk("lsb_frame_full", q0, exp_a);
        chk("lsb_frame_low_word", {154'd0, q0[15:0]}, {154'd0, 16'h0001});
        chk("lsb_frame_top_bits", {160'd0, q0[169:160]}, {160'd0, 10'h00B});

        // ---------------- back-to-back frames ----------------
        exp_a = '0;
        exp_b = '0;
        for (int k = 0; k < 11; k++) begin
            exp_a = exp_a | (170'(16'h0100 + k) << (16 * k));
            exp_b = exp_b | (170'(16'h0100 + 11 + k) << (16 * k));
        end
        ndone = 0; first_done = -1; second_done = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            p0 = (cyc < 22);
            d0 = 16'(16'h0100 + cyc);
            tick();
            if (done0) begin
                if (ndone == 0) begin
                    first_done = cyc;
                    chk("b2b_frame1", q0, exp_a);
                end else begin
                    second_done = cyc;
                end
                ndone++;
            end
        end
        p0 = 1'b0;
        chk("b2b_done_count", 170'(ndone), 170'd2);
        chk("b2b_first_latency", 170'(first_done), 170'd11);
        chk("b2b_done_spacing", 170'(second_done - first_done), 170'd11);
        chk("b2b_frame2", q0, exp_b);

        // ---------------- MSB-first, 40-bit output ----------------
        msb_words[0] = 16'hABCD; msb_words[1] = 16'h1234; msb_words[2] = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            p1 = 1'b1; d1 = msb_words[i];
            tick();
            chk($sformatf("msb_word_cnt%0d", i), {168'd0, cnt1}, 170'(i + 1));
        end
        p1 = 1'b0;
        tick();
        chk("msb_done", {169'd0, done1}, 170'd1);
        chk("msb_data_out", {130'd0, q1}, {130'd0, 40'hABCD123456});
        chk("msb_word_cnt_after", {168'd0, cnt1}, 170'd0);
        tick();
        chk("msb_done_one_cycle", {169'd0, done1}, 170'd0);

        // ---------------- timeout ----------------
        exp_t = '0;
        for (int k = 0; k < 11; k++) begin
            p2 = 1'b1; d2 = 16'(16'h2000 + k);
            exp_t = exp_t | (170'(16'h2000 + k) << (16 * k));
            tick();
        end
        p2 = 1'b0;
        tick();
        chk("to_frame_done", {169'd0, done2}, 170'd1);
        chk("to_frame_data", q2, exp_t);
        chk("to_frame_top_trunc", {160'd0, q2[169:160]}, {160'd0, 10'h00A});
        tick();
        for (int i = 0; i < 3; i++) begin
            p2 = 1'b1; d2 = 16'(16'h3000 + i);
            tick();
        end
        p2 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) begin
                chk($sformatf("to_idle%0d_err", i), {169'd0, terr2}, 170'd0);
                chk($sformatf("to_idle%0d_cnt", i), {166'd0, cnt2}, 170'd3);
            end else begin
                chk("to_fire_err", {169'd0, terr2}, 170'd1);
                chk("to_fire_cnt", {166'd0, cnt2}, 170'd0);
                chk("to_fire_busy", {169'd0, busy2}, 170'd0);
            end
        end
        tick();
        chk("to_err_one_cycle", {169'd0, terr2}, 170'd0);
        chk("to_data_unchanged", q2, exp_t);

        // strobe arriving in the expiry cycle wins
        for (int i = 0; i < 3; i++) begin
            p2 = 1'b1; d2 = 16'(16'h4000 + i);
            tick();
        end
        p2 = 1'b0;
        repeat (3) tick();
        p2 = 1'b1; d2 = 16'h4003;
        tick();
        p2 = 1'b0;
        chk("to_limit_pulse_err", {169'd0, terr2}, 170'd0);
        chk("to_limit_pulse_cnt", {166'd0, cnt2}, 170'd4);
        chk("to_limit_pulse_busy", {169'd0, busy2}, 170'd1);
        c2 = 1'b1;
        tick();
        c2 = 1'b0;
        chk("to_clear_cnt", {166'd0, cnt2}, 170'd0);
        chk("to_clear_data", q2, exp_t);

        // ---------------- async reset mid-frame ----------------
        for (int i = 0; i < 4; i++) begin
            p0 = 1'b1; d0 = 16'(16'h5000 + i);
            tick();
        end
        chk("ar_pre_cnt", {166'd0, cnt0}, 170'd4);
        #3 rst_n = 1'b0;
        #1;
        chk("ar_data_out", q0, 170'd0);
        chk("ar_word_cnt", {166'd0, cnt0}, 170'd0);
        chk("ar_busy", {169'd0, busy0}, 170'd0);
        chk("ar_dut2_data_out", q2, 170'd0);
        p0 = 1'b0;
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done0) ndone++;
        end
        chk("ar_no_done", 170'(ndone), 170'd0);
        chk("ar_data_stays_zero", q0, 170'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
